phy_mdio_sequencer: RTL and testbench
=====================================

# phy_mdio_sequencer

Brings up and supervises the Gigabit PHY over MDIO, and gates the RGMII receive path.
- After reset it programs the PHY's RGMII clock and data pad skew extended registers, so RX_CLK arrives about 2 ns after RXD/RX_CTL.
- It then polls link status and speed, driving `speed_1Gbit` and holding the RGMII receiver in reset until the link is up at 1000 Mb/s.
- It sits beside the receive front end in the ethernet top level and is the only MDIO master.

## Interface
Parameters:
- CLK_DIV, 25: system clocks per MDC half-period; MDC = f_clock / (2·CLK_DIV); minimum 2.
- PHY_ADDR, 5'd7: MDIO PHY address.
- STARTUP_CYCLES, 24'd2_500_000: wait after reset before the first MDIO frame.
- POLL_CYCLES, 24'd1_250_000: idle gap between poll rounds.
- RX_CLK_SKEW, 16'hF0F0: value written to extended reg 260 (clock/control pad skew).
- RX_DATA_SKEW, 16'h0000: value written to extended reg 261 (RX data pad skew).

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- mdc, out, 1: MDIO clock.
- mdio_o, out, 1: MDIO output data.
- mdio_oe, out, 1: MDIO output enable; the top level builds the tristate.
- mdio_i, in, 1: MDIO input data; synchronised internally with 2 flops.
- cfg_done, out, 1: skew programming complete.
- link_up, out, 1: last polled link status.
- speed_1Gbit, out, 1: last polled speed is 1000 Mb/s.
- rx_reset, out, 1: high holds the receive path in reset.

## Operation
- States: WAIT_START → W260_CTL → W260_DAT → W261_CTL → W261_DAT → POLL_WAIT → R_BMSR → R_PHYCTL → POLL_WAIT (loops).
- WAIT_START: counts STARTUP_CYCLES, then advances.
- W260_CTL: write reg 0x0B = 16'h8104.
- W260_DAT: write reg 0x0C = RX_CLK_SKEW.
- W261_CTL: write reg 0x0B = 16'h8105.
- W261_DAT: write reg 0x0C = RX_DATA_SKEW.
- After W261_DAT completes, cfg_done rises and stays high until reset.
- POLL_WAIT: counts POLL_CYCLES, then starts R_BMSR.
- R_BMSR: read reg 0x01. link = bit 2, except a result of 16'hFFFF (no PHY answering) forces link = 0.
- R_PHYCTL: read reg 0x1F. speed = bit 6. Runs even when link = 0.
- At the end of R_PHYCTL, link_up and speed_1Gbit update together in one cycle; speed_1Gbit = link & speed.
- rx_reset = !(cfg_done & link_up & speed_1Gbit), registered.
- MDIO frame, 64 bits, MSB first:
  - 32 preamble ones;
  - ST 01;
  - OP 01 (write) or 10 (read);
  - PHY_ADDR[4:0], REG[4:0];
  - TA: 10 for a write; for a read, bit 46 released and bit 47 sampled-ignored;
  - 16 data bits.
- Read: mdio_oe = 0 from the first TA bit through the end of the frame. Write: mdio_oe = 1 for all 64 bits.
- Between frames: mdio_oe = 0, mdc held low.

## Timing
- Reset values: mdc 0, mdio_o 1, mdio_oe 0, cfg_done 0, link_up 0, speed_1Gbit 0, rx_reset 1. State = WAIT_START with counters cleared.
- One MDIO bit = 2·CLK_DIV clocks: mdc is low for CLK_DIV clocks, then high for CLK_DIV clocks.
- mdio_o/mdio_oe change only in the clock where mdc falls; the first bit is driven in the clock where the frame starts.
- mdio_i is sampled in the clock where mdc rises, using the synchronised value.
- Frame length = 128·CLK_DIV clocks. The next frame starts in the cycle after the previous one ends.
- rx_reset deasserts 1 clock after the link_up/speed_1Gbit update. It asserts 1 clock after a poll shows link down or 100M.
- Reset mid-frame: all outputs take reset values asynchronously and the sequence restarts at WAIT_START. There is no partial-frame resume.
- Counter widths: 24 bits; CLK_DIV counter width is $clog2(CLK_DIV).

## Structure
- Package phy_mdio_pkg holds:
  - register addresses: BMSR 5'h01, EXT_CTL 5'h0B, EXT_WDATA 5'h0C, PHYCTL 5'h1F;
  - ext-write control words 16'h8104 and 16'h8105;
  - opcodes OP_WR 2'b01, OP_RD 2'b10;
  - the state enum.
- Sub-module mdio_frame:
  - inputs: start, rd, reg, wdata;
  - outputs: done (1-cycle pulse), rdata[15:0], mdc, mdio_o, mdio_oe;
  - owns the divider and the 64-bit shift.
- The sequencer FSM instantiates one mdio_frame and issues start only when it is idle.

## Test plan
- Use CLK_DIV=2, STARTUP_CYCLES=10, POLL_CYCLES=20 and a bus-functional PHY model on mdio_i throughout.
- Write sequence: release reset, run → four write frames decoded in order: (0x0B, 0x8104), (0x0C, RX_CLK_SKEW), (0x0B, 0x8105), (0x0C, RX_DATA_SKEW). Each is 256 clocks long and carries PHYAD=7; cfg_done rises after the fourth.
- Link up at 1G: model returns BMSR = 16'h796D and PHYCTL = 16'h0040 → link_up = 1 and speed_1Gbit = 1 at the end of R_PHYCTL; rx_reset = 0 one clock later.
- Link at 100M: PHYCTL = 16'h0020 → link_up = 1, speed_1Gbit = 0, rx_reset stays 1.
- Link drop: once up, the model returns BMSR = 16'h7969 → link_up and speed_1Gbit fall on the next poll; rx_reset = 1 one clock later.
- No PHY: mdio_i held at 1 → BMSR reads 16'hFFFF, link_up = 0, polling continues.
- Turnaround and reset mid-frame: during a read, mdio_oe = 0 from bit 46 onward. Assert reset_n = 0 mid-frame → mdc = 0 and mdio_oe = 0 immediately; after release the write sequence restarts from the first frame.

Source files
------------

// File: rtl/phy_mdio_pkg.sv
// Shared constants, state encoding and the MDIO frame builder for the PHY bring-up sequencer.
package phy_mdio_pkg;

  localparam logic [4:0]  REG_BMSR      = 5'h01;
  localparam logic [4:0]  REG_EXT_CTL   = 5'h0B;
  localparam logic [4:0]  REG_EXT_WDATA = 5'h0C;
  localparam logic [4:0]  REG_PHYCTL    = 5'h1F;

  localparam logic [15:0] EXT_CTL_260   = 16'h8104;
  localparam logic [15:0] EXT_CTL_261   = 16'h8105;

  localparam logic [1:0]  OP_WR         = 2'b01;
  localparam logic [1:0]  OP_RD         = 2'b10;

  typedef enum logic [2:0] {
    WAIT_START,
    W260_CTL,
    W260_DAT,
    W261_CTL,
    W261_DAT,
    POLL_WAIT,
    R_BMSR,
    R_PHYCTL
  } state_t;

  // Full 64-bit clause-22 frame, MSB first; read frames carry ones in TA/data.
  function automatic logic [63:0] build_frame(input logic       rd,
                                              input logic [4:0]  phy_addr,
                                              input logic [4:0]  reg_addr,
                                              input logic [15:0] wdata);
    return {32'hFFFF_FFFF, 2'b01, (rd ? OP_RD : OP_WR), phy_addr, reg_addr,
            (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wdata)};
  endfunction

endpackage

// File: rtl/mdio_frame.sv
// One MDIO frame engine: MDC divider, 64-bit shift out, read data capture on MDC rise.
module mdio_frame
  import phy_mdio_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [4:0] PHY_ADDR = 5'd7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rd,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  input  logic        mdio_i,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe
);

  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [1:0]    sync;
  logic          active;
  logic          rd_q;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [63:0]   shift;
  logic [63:0]   frame_word;

  assign frame_word = build_frame(rd, PHY_ADDR, reg_addr, wdata);
  assign busy       = active;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      active  <= 1'b0;
      rd_q    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '1;
      done    <= 1'b0;
      rdata   <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
    end else begin
      sync <= {sync[0], mdio_i};
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          rd_q    <= rd;
          div_cnt <= '0;
          bit_cnt <= '0;
          shift   <= frame_word;
          mdc     <= 1'b0;
          mdio_o  <= frame_word[63];
          mdio_oe <= 1'b1;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!mdc) begin
          // Every rise shifts in; after 64 rises only the 16 data bits remain.
          mdc   <= 1'b1;
          rdata <= {rdata[14:0], sync[1]};
        end else begin
          mdc <= 1'b0;
          if (bit_cnt == 6'd63) begin
            active  <= 1'b0;
            done    <= 1'b1;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {shift[62:0], 1'b1};
            mdio_o  <= shift[62];
            // Reads release the line from the first turnaround bit (46) onward.
            mdio_oe <= !(rd_q && (bit_cnt >= 6'd45));
          end
        end
      end
    end
  end

endmodule

// File: rtl/phy_mdio_sequencer.sv
// PHY bring-up: programs RGMII pad skew, then polls link/speed and gates the RGMII receiver.
module phy_mdio_sequencer
  import phy_mdio_pkg::*;
#(
  parameter int          CLK_DIV        = 25,
  parameter logic [4:0]  PHY_ADDR       = 5'd7,
  parameter logic [23:0] STARTUP_CYCLES = 24'd2_500_000,
  parameter logic [23:0] POLL_CYCLES    = 24'd1_250_000,
  parameter logic [15:0] RX_CLK_SKEW    = 16'hF0F0,
  parameter logic [15:0] RX_DATA_SKEW   = 16'h0000
) (
  input  logic clock,
  input  logic reset_n,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i,
  output logic cfg_done,
  output logic link_up,
  output logic speed_1Gbit,
  output logic rx_reset
);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic        issued, issued_n;
  logic        cfg_done_n, link_tmp, link_tmp_n, link_up_n, speed_n;

  logic        start, rd, busy, done;
  logic [4:0]  reg_addr;
  logic [15:0] wdata, rdata;

  mdio_frame #(.CLK_DIV(CLK_DIV), .PHY_ADDR(PHY_ADDR)) u_frame (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .rd       (rd),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .mdio_i   (mdio_i),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_START;
      cnt         <= '0;
      issued      <= 1'b0;
      cfg_done    <= 1'b0;
      link_tmp    <= 1'b0;
      link_up     <= 1'b0;
      speed_1Gbit <= 1'b0;
      rx_reset    <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      issued      <= issued_n;
      cfg_done    <= cfg_done_n;
      link_tmp    <= link_tmp_n;
      link_up     <= link_up_n;
      speed_1Gbit <= speed_n;
      rx_reset    <= !(cfg_done && link_up && speed_1Gbit);
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    issued_n   = issued;
    cfg_done_n = cfg_done;
    link_tmp_n = link_tmp;
    link_up_n  = link_up;
    speed_n    = speed_1Gbit;
    start      = 1'b0;
    rd         = 1'b0;
    reg_addr   = REG_BMSR;
    wdata      = '0;

    case (state)
      WAIT_START, POLL_WAIT: begin
        if (cnt == ((state == WAIT_START) ? STARTUP_CYCLES : POLL_CYCLES) - 24'd1) begin
          cnt_n   = '0;
          state_n = (state == WAIT_START) ? W260_CTL : R_BMSR;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      W260_CTL: begin reg_addr = REG_EXT_CTL;   wdata = EXT_CTL_260;  end
      W260_DAT: begin reg_addr = REG_EXT_WDATA; wdata = RX_CLK_SKEW;  end
      W261_CTL: begin reg_addr = REG_EXT_CTL;   wdata = EXT_CTL_261;  end
      W261_DAT: begin reg_addr = REG_EXT_WDATA; wdata = RX_DATA_SKEW; end
      R_BMSR:   begin reg_addr = REG_BMSR;      rd = 1'b1;            end
      R_PHYCTL: begin reg_addr = REG_PHYCTL;    rd = 1'b1;            end
      default:  state_n = WAIT_START;
    endcase

    // Frame states: issue one start while the engine is idle, advance on its done.
    if (state != WAIT_START && state != POLL_WAIT) begin
      start = !issued && !busy;
      if (start) issued_n = 1'b1;
      if (done) begin
        issued_n = 1'b0;
        case (state)
          W260_CTL: state_n = W260_DAT;
          W260_DAT: state_n = W261_CTL;
          W261_CTL: state_n = W261_DAT;
          W261_DAT: begin state_n = POLL_WAIT; cfg_done_n = 1'b1; end
          R_BMSR: begin
            state_n    = R_PHYCTL;
            link_tmp_n = (rdata != 16'hFFFF) && rdata[2];
          end
          default: begin
            state_n   = POLL_WAIT;
            link_up_n = link_tmp;
            speed_n   = link_tmp && rdata[6];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phy_mdio_sequencer.sv
// Self-checking bench: MDIO PHY bus-functional model plus a link/speed reference model.
module tb_phy_mdio_sequencer;

  localparam int          CLK_DIV   = 2;
  localparam logic [15:0] CLK_SKEW  = 16'hF0F0;
  localparam logic [15:0] DATA_SKEW = 16'h0000;
  localparam logic [63:0] RD_OE     = 64'hFFFF_FFFF_FFFC_0000;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    int          oe_cycles;
  } frame_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic mdio_i = 1'b1;
  logic mdc, mdio_o, mdio_oe, cfg_done, link_up, speed_1Gbit, rx_reset;

  int tests = 0;
  int fails = 0;

  frame_t      frames[$];
  logic [15:0] bmsr_val = 16'h796D;
  logic [15:0] phyctl_val = 16'h0040;
  bit          no_phy = 1'b0;
  bit          m_link = 1'b0;
  bit          m_speed = 1'b0;

  int          mon_idx = 0;
  bit          mon_pending = 1'b0;
  logic        mon_prev_mdc = 1'b0;
  logic [63:0] mon_bits = '0;
  logic [63:0] mon_oe = '0;
  int          mon_oe_cnt = 0;

  phy_mdio_sequencer #(
    .CLK_DIV        (CLK_DIV),
    .PHY_ADDR       (5'd7),
    .STARTUP_CYCLES (24'd10),
    .POLL_CYCLES    (24'd20),
    .RX_CLK_SKEW    (CLK_SKEW),
    .RX_DATA_SKEW   (DATA_SKEW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mdc         (mdc),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .mdio_i      (mdio_i),
    .cfg_done    (cfg_done),
    .link_up     (link_up),
    .speed_1Gbit (speed_1Gbit),
    .rx_reset    (rx_reset)
  );

  initial forever #5 clock = ~clock;

  // PHY model: decodes bits at MDC rise, drives TA/data for reads one bit ahead.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_idx      = 0;
      mon_pending  = 1'b0;
      mon_oe_cnt   = 0;
      mon_prev_mdc = 1'b0;
      mdio_i       = 1'b1;
    end else begin
      if (mdio_oe === 1'b1) mon_oe_cnt++;
      if (mdc === 1'b1 && mon_prev_mdc === 1'b0 && !mon_pending) begin
        logic [15:0] resp;
        int nxt;
        mon_bits[63-mon_idx] = mdio_o;
        mon_oe[63-mon_idx]   = mdio_oe;
        nxt  = mon_idx + 1;
        resp = (mon_bits[22:18] == 5'h01) ? bmsr_val : phyctl_val;
        if (!no_phy && mon_idx >= 35 && mon_bits[29:28] == 2'b10 && nxt >= 47 && nxt <= 63)
          mdio_i = (nxt == 47) ? 1'b0 : resp[63-nxt];
        else
          mdio_i = 1'b1;
        mon_idx++;
        if (mon_idx == 64) mon_pending = 1'b1;
      end else if (mdc === 1'b0 && mon_prev_mdc === 1'b1 && mon_pending) begin
        frames.push_back('{bits: mon_bits, oe: mon_oe, oe_cycles: mon_oe_cnt});
        mon_idx     = 0;
        mon_pending = 1'b0;
        mon_oe_cnt  = 0;
      end
      mon_prev_mdc = mdc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic get_frame(input string tag, output frame_t f);
    int n = 0;
    while (frames.size() == 0 && n < 3000) begin
      step(1);
      n++;
    end
    if (frames.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: no frame seen, observed 0 frames expected 1", tag);
      finish_run();
    end
    f = frames.pop_front();
  endtask

  task automatic expect_write(input string tag, input logic [4:0] ra, input logic [15:0] data);
    frame_t f;
    get_frame(tag, f);
    check({tag, "_preamble"}, f.bits[63:32], 64'hFFFF_FFFF);
    check({tag, "_st_op"},    f.bits[31:28], 4'b0101);
    check({tag, "_phyad"},    f.bits[27:23], 5'd7);
    check({tag, "_reg"},      f.bits[22:18], ra);
    check({tag, "_ta"},       f.bits[17:16], 2'b10);
    check({tag, "_data"},     f.bits[15:0],  data);
    check({tag, "_oe_bits"},  f.oe, '1);
    check({tag, "_length"},   f.oe_cycles, 128 * CLK_DIV);
  endtask

  task automatic expect_writes(input string tag);
    expect_write({tag, "_w260ctl"}, 5'h0B, 16'h8104);
    expect_write({tag, "_w260dat"}, 5'h0C, CLK_SKEW);
    expect_write({tag, "_w261ctl"}, 5'h0B, 16'h8105);
    check({tag, "_cfg_done_early"}, cfg_done, 1'b0);
    expect_write({tag, "_w261dat"}, 5'h0C, DATA_SKEW);
    step(3);
    check({tag, "_cfg_done"}, cfg_done, 1'b1);
  endtask

  task automatic expect_read(input string tag, input logic [4:0] ra);
    frame_t f;
    get_frame(tag, f);
    check({tag, "_op"},     f.bits[31:28], 4'b0110);
    check({tag, "_reg"},    {f.bits[27:23], f.bits[22:18]}, {5'd7, ra});
    check({tag, "_ta_oe"},  f.oe, RD_OE);
  endtask

  // Reference: one poll round, expressed directly from the link/speed rules.
  task automatic do_poll(input string tag, input logic [15:0] b, input logic [15:0] p);
    logic [15:0] eb, ep;
    bit exp_link, exp_speed, old_rx, new_rx;
    int n = 0;
    bmsr_val   = b;
    phyctl_val = p;
    expect_read({tag, "_bmsr"},   5'h01);
    expect_read({tag, "_phyctl"}, 5'h1F);
    eb        = no_phy ? 16'hFFFF : b;
    ep        = no_phy ? 16'hFFFF : p;
    exp_link  = (eb != 16'hFFFF) && eb[2];
    exp_speed = exp_link && ep[6];
    old_rx    = !(m_link && m_speed);
    new_rx    = !(exp_link && exp_speed);
    while (!(link_up === exp_link && speed_1Gbit === exp_speed) && n < 16) begin
      step(1);
      n++;
    end
    check({tag, "_link_up"},     link_up, exp_link);
    check({tag, "_speed_1Gbit"}, speed_1Gbit, exp_speed);
    check({tag, "_rx_reset_at_update"}, rx_reset, old_rx);
    step(1);
    check({tag, "_rx_reset_after"}, rx_reset, new_rx);
    m_link  = exp_link;
    m_speed = exp_speed;
  endtask

  initial begin
    int n;
    step(3);
    check("reset_mdc", mdc, 1'b0);
    check("reset_mdio_o", mdio_o, 1'b1);
    check("reset_mdio_oe", mdio_oe, 1'b0);
    check("reset_cfg_done", cfg_done, 1'b0);
    check("reset_link_up", link_up, 1'b0);
    check("reset_speed", speed_1Gbit, 1'b0);
    check("reset_rx_reset", rx_reset, 1'b1);

    reset_n = 1'b1;
    expect_writes("boot");

    do_poll("up_1g",   16'h796D, 16'h0040);
    do_poll("at_100m", 16'h796D, 16'h0020);
    do_poll("up_1g_b", 16'h796D, 16'h0040);
    do_poll("drop",    16'h7969, 16'h0040);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] rb, rp;
      rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      rp = 16'($urandom());
      do_poll($sformatf("rand%0d", i), rb, rp);
    end

    do_poll("pre_reset_up", 16'h796D, 16'h0040);

    // Abort a read frame while MDC is high, deep in the data phase.
    n = 0;
    while (!(mon_idx >= 50 && mdc === 1'b1) && n < 3000) begin
      step(1);
      n++;
    end
    check("midframe_reached", (mon_idx >= 50 && mdc === 1'b1), 1'b1);
    reset_n = 1'b0;
    #1;
    check("midreset_mdc", mdc, 1'b0);
    check("midreset_mdio_oe", mdio_oe, 1'b0);
    check("midreset_mdio_o", mdio_o, 1'b1);
    check("midreset_link_up", link_up, 1'b0);
    check("midreset_speed", speed_1Gbit, 1'b0);
    check("midreset_cfg_done", cfg_done, 1'b0);
    check("midreset_rx_reset", rx_reset, 1'b1);
    step(2);
    frames.delete();
    m_link  = 1'b0;
    m_speed = 1'b0;
    reset_n = 1'b1;
    expect_writes("restart");

    do_poll("restart_up", 16'h796D, 16'h0040);
    no_phy = 1'b1;
    do_poll("no_phy1", 16'h796D, 16'h0040);
    do_poll("no_phy2", 16'h796D, 16'h0040);

    finish_run();
  end

endmodule
